// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 padding front end.
package sha3_pkg;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [7:0] SHA3_SUFFIX  = 8'h06;
    localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
    localparam logic [7:0] PAD_LAST     = 8'h80;

    // Rate of the sponge: permutation width minus capacity (2 * digest).
    function automatic int rate_bits(input int d, input int b);
        return b - 2 * d;
    endfunction

endpackage

// File: rtl/sha3_lane_mask.sv
// Masks the unused tail bytes of a message word and marks the byte
// position where padding starts inside that word (none when the word is full).
module sha3_lane_mask (
    input  logic [63:0] word,
    input  logic [3:0]  nbytes,
    output logic [63:0] masked,
    output logic [7:0]  first_pad
);

    logic [3:0] n;

    // Clamp the byte count to a full word, then keep bytes below it.
    always_comb begin
        n         = (nbytes > 4'd8) ? 4'd8 : nbytes;
        masked    = '0;
        first_pad = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n) begin
                masked[8*k +: 8] = word[8*k +: 8];
            end
            first_pad[k] = (4'(k) == n);
        end
    end

endmodule

// File: rtl/sha3_padder.sv
// Assembles 64-bit message words into rate blocks, appends the domain
// suffix and pad10*1, and hands blocks to the sponge over valid/ready.
//
//   state | meaning
//   FILL  | accepting words into the block buffer
//   EMIT  | block presented; pad_pending adds a trailing pad-only block
module sha3_padder
    import sha3_pkg::*;
#(
    parameter int         D      = 256,
    parameter int         B      = 1600,
    parameter int         R      = rate_bits(D, B),
    parameter logic [7:0] SUFFIX = SHA3_SUFFIX
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [3:0]   in_bytes,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [R-1:0] blk_data,
    output logic         blk_last
);

    localparam int NL = R / 64;
    localparam int CW = $clog2(NL + 1);
    localparam logic [R-1:0] PAD_BLOCK = {PAD_LAST, {(R-16){1'b0}}, SUFFIX};

    if ((R % 64) != 0 || R < 128 || B != 1600) begin : g_bad_rate
        $error("sha3_padder: rate must be a multiple of 64 bits with B=1600");
    end

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [R-1:0]   buf_q;
    logic [R-1:0]   buf_nxt;
    logic           pad_pending;

    logic [3:0]     bytes_req;
    logic [63:0]    masked;
    logic [7:0]     first_pad;
    logic [63:0]    word_sfx;
    logic           last_full;
    logic           cnt_end;
    logic           blk_full;
    logic           spill;

    // Non-final words are always full regardless of in_bytes.
    assign bytes_req = in_last ? in_bytes : 4'd8;

    sha3_lane_mask u_mask (
        .word      (in_data),
        .nbytes    (bytes_req),
        .masked    (masked),
        .first_pad (first_pad)
    );

    assign last_full = (first_pad == 8'h00);
    assign cnt_end   = (cnt == CW'(NL - 1));
    // Final word exactly fills the block: padding needs a block of its own.
    assign blk_full  = in_last && last_full && cnt_end;
    // Final word is full but the block is not: suffix lands in the next lane.
    assign spill     = in_last && last_full && !cnt_end;

    // Insert the suffix byte inside the current word when it falls there.
    always_comb begin
        word_sfx = masked;
        for (int k = 0; k < 8; k++) begin
            if (in_last && first_pad[k]) begin
                word_sfx[8*k +: 8] = masked[8*k +: 8] | SUFFIX;
            end
        end
    end

    // Next buffer contents for an accepted word, including any padding.
    always_comb begin
        buf_nxt = buf_q;
        for (int j = 0; j < NL; j++) begin
            if (cnt == CW'(j)) begin
                buf_nxt[64*j +: 64] = word_sfx;
            end
        end
        for (int j = 1; j < NL; j++) begin
            if (spill && (cnt == CW'(j - 1))) begin
                buf_nxt[64*j +: 8] = SUFFIX;
            end
        end
        if (in_last && !blk_full) begin
            buf_nxt[R-8 +: 8] = buf_nxt[R-8 +: 8] | PAD_LAST;
        end
    end

    // Block FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            cnt         <= '0;
            buf_q       <= '0;
            pad_pending <= 1'b0;
            in_ready    <= 1'b1;
            blk_valid   <= 1'b0;
            blk_last    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        buf_q <= buf_nxt;
                        cnt   <= cnt + 1'b1;
                        if (in_last || cnt_end) begin
                            state       <= EMIT;
                            in_ready    <= 1'b0;
                            blk_valid   <= 1'b1;
                            blk_last    <= in_last && !blk_full;
                            pad_pending <= blk_full;
                        end
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        if (pad_pending) begin
                            buf_q       <= PAD_BLOCK;
                            pad_pending <= 1'b0;
                            blk_last    <= 1'b1;
                        end else begin
                            state     <= FILL;
                            buf_q     <= '0;
                            cnt       <= '0;
                            blk_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            blk_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign blk_data = buf_q;

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: a byte-level padding model produces
// the expected blocks, and a compare process checks every presented block.
module tb_sha3_padder;

    localparam int R  = 1088;
    localparam int RB = R / 8;
    localparam logic [7:0] SFX = 8'h06;

    typedef struct packed {
        logic         last;
        logic [R-1:0] data;
    } blk_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic [3:0]   in_bytes = '0;
    logic         in_last = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [R-1:0] blk_data;
    logic         blk_last;

    blk_t exp_q[$];
    blk_t mdl_out[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    bit   chk_en = 0;
    bit   force_bp = 0;

    sha3_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    // Message -> padded byte string -> list of rate blocks.
    task automatic model(input logic [7:0] msg[$]);
        int len;
        int nblk;
        logic [7:0] pb[];
        blk_t b;
        len  = msg.size();
        nblk = len / RB + 1;
        pb   = new[nblk * RB];
        foreach (pb[i]) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = msg[i];
        pb[len]           = pb[len] | SFX;
        pb[nblk * RB - 1] = pb[nblk * RB - 1] | 8'h80;
        mdl_out.delete();
        for (int k = 0; k < nblk; k++) begin
            b.data = '0;
            for (int i = 0; i < RB; i++) b.data[8*i +: 8] = pb[k * RB + i];
            b.last = (k == nblk - 1);
            mdl_out.push_back(b);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
        int first;
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            first = -1;
            for (int i = 0; i < RB; i++)
                if (first < 0 && act[8*i +: 8] !== exp[8*i +: 8]) first = i;
            $display("FAIL %s: byte %0d got %02h expected %02h at %0t",
                     name, first, act[8*first +: 8], exp[8*first +: 8], $time);
        end
    endtask

    // Compare DUT outputs with the head of the expected block queue.
    always @(negedge clk) begin
        if (chk_en) begin
            chk_bit("ready_vs_valid", in_ready, !blk_valid);
            if (blk_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_block: blk_valid=1 with no block expected at %0t", $time);
                end else begin
                    chk_blk("blk_data", blk_data, exp_q[0].data);
                    chk_bit("blk_last", blk_last, exp_q[0].last);
                    if (blk_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Count accepted input words.
    always @(posedge clk) begin
        if (reset && in_valid && in_ready) n_acc++;
    end

    // Random sponge backpressure, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            blk_ready = force_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic l);
        int guard;
        logic acc;
        guard = 0;
        @(negedge clk);
        #1;
        while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = l;
        forever begin
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            guard++;
            if (guard > 300) begin
                n_chk++;
                n_fail++;
                $display("FAIL word_accept_timeout: in_ready stayed 0 for %0d cycles", guard);
                break;
            end
            @(negedge clk);
            #1;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        int len;
        int nw;
        int nb;
        logic [63:0] d;
        logic [3:0] nbs;
        logic l;
        model(msg);
        foreach (mdl_out[i]) exp_q.push_back(mdl_out[i]);
        len = msg.size();
        if (len == 0) nw = 1;
        else if (len % 8 == 0 && $urandom_range(0, 3) == 0) nw = len / 8 + 1;
        else nw = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            nb = len - 8 * w;
            if (nb > 8) nb = 8;
            if (nb < 0) nb = 0;
            d = {$urandom, $urandom};
            for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[8 * w + k];
            l = (w == nw - 1);
            if (!l) nbs = 4'($urandom_range(0, 15));
            else if (nb == 8 && $urandom_range(0, 2) == 0) nbs = 4'($urandom_range(9, 15));
            else nbs = 4'(nb);
            send_word(d, nbs, l);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || blk_valid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk_int("drain_remaining", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic void rand_msg(input int len, output logic [7:0] m[$]);
        m.delete();
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    endfunction

    task automatic print_summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        print_summary();
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m[$];
        logic [7:0] abc[$];
        logic [R-1:0] pad_blk;
        logic [R-1:0] abc_blk;
        logic [R-1:0] snap;
        int dlen[8];
        int n0;
        int guard;

        abc = '{8'h61, 8'h62, 8'h63};
        pad_blk = '0;
        pad_blk[7:0] = 8'h06;
        pad_blk[R-8 +: 8] = 8'h80;
        abc_blk = '0;
        abc_blk[31:0] = 32'h06636261;
        abc_blk[R-8 +: 8] = 8'h80;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_blk_valid", blk_valid, 1'b0);
        chk_bit("rst_blk_last", blk_last, 1'b0);
        chk_blk("rst_blk_data", blk_data, '0);
        reset = 1'b1;
        chk_en = 1;

        // Hand-computed pins on the model.
        m.delete();
        model(m);
        chk_int("pin_empty_nblk", mdl_out.size(), 1);
        chk_blk("pin_empty_data", mdl_out[0].data, pad_blk);
        chk_bit("pin_empty_last", mdl_out[0].last, 1'b1);
        model(abc);
        chk_blk("pin_abc_data", mdl_out[0].data, abc_blk);
        rand_msg(135, m);
        model(m);
        chk_int("pin_135_byte135", int'(mdl_out[0].data[R-8 +: 8]), 8'h86);
        rand_msg(136, m);
        model(m);
        chk_int("pin_136_nblk", mdl_out.size(), 2);
        chk_bit("pin_136_first_last", mdl_out[0].last, 1'b0);
        chk_blk("pin_136_pad_data", mdl_out[1].data, pad_blk);

        // Directed lengths around word and block boundaries.
        m.delete();
        send_msg(m);
        send_msg(abc);
        dlen = '{135, 136, 7, 8, 271, 272, 137, 16};
        foreach (dlen[i]) begin
            rand_msg(dlen[i], m);
            send_msg(m);
        end
        wait_drain();

        // Backpressure: block held while input keeps offering a word.
        force_bp = 1;
        rand_msg(20, m);
        fork
            begin
                send_msg(abc);
                send_msg(m);
            end
            begin
                guard = 0;
                while (!blk_valid && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
                chk_bit("bp_blk_valid", blk_valid, 1'b1);
                snap = blk_data;
                chk_blk("bp_abc_block", snap, abc_blk);
                n0 = n_acc;
                repeat (10) begin
                    @(negedge clk);
                    chk_blk("bp_data_stable", blk_data, snap);
                    chk_bit("bp_last_stable", blk_last, 1'b1);
                    chk_bit("bp_in_ready", in_ready, 1'b0);
                end
                chk_int("bp_words_accepted", n_acc, n0);
                force_bp = 0;
            end
        join
        wait_drain();

        // Random messages.
        repeat (24) begin
            rand_msg(($urandom_range(0, 3) == 0) ? 136 * $urandom_range(1, 2) - $urandom_range(0, 1)
                                                 : $urandom_range(0, 300), m);
            send_msg(m);
        end
        wait_drain();

        // Reset in the middle of a message discards it.
        for (int w = 0; w < 5; w++) send_word({$urandom, $urandom}, 4'd8, 1'b0);
        @(negedge clk);
        #1;
        chk_en = 0;
        reset = 1'b0;
        @(negedge clk);
        chk_bit("mid_rst_in_ready", in_ready, 1'b1);
        chk_bit("mid_rst_blk_valid", blk_valid, 1'b0);
        chk_blk("mid_rst_blk_data", blk_data, '0);
        #1;
        reset = 1'b1;
        chk_en = 1;
        send_msg(abc);
        guard = 0;
        while (!blk_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk_blk("post_rst_abc", blk_data, abc_blk);
        wait_drain();

        print_summary();
        $finish;
    end

endmodule

// File: doc/sha3_padder.md
Name: sha3_padder

Overview:
- Upstream feeder for the keccak sponge core.
- Accepts a byte-granular message as a stream of 64-bit words and assembles r-bit rate blocks.
- Applies SHA-3 domain suffix and pad10*1 padding (FIPS 202) and presents one block per valid/ready handshake.
- The sponge controller drives keccak enable/message from blk_valid/blk_data and treats blk_last as the final absorb.

Parameters:
- D, 256, digest length in bits; capacity C = 2*D.
- B, 1600, permutation width in bits (l=6 only).
- R, B-2*D, rate in bits; must be a multiple of 64 (elaboration assertion). Default 1088, i.e. 17 lanes, 136 bytes.
- SUFFIX, 8'h06, domain-separation byte OR-ed at the first pad byte (8'h1F for SHAKE).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept a word
- in_data  in  64  message word; byte k = in_data[8k+:8], earliest byte at k=0
- in_bytes  in  4  valid bytes in word, 0..8; honoured only with in_last, otherwise 8 is used
- in_last  in  1  final word of message
- blk_valid  out  1  rate block available
- blk_ready  in  1  sponge consumes block
- blk_data  out  R  rate block; lane j = blk_data[64j+:64], byte i of block = blk_data[8i+:8]
- blk_last  out  1  block is the final (padded) block of the message

Behaviour:
- Reset (reset=0, async): state=FILL, lane count=0, buffer all-zero; in_ready=1, blk_valid=0, blk_last=0, blk_data=0.
- Lanes per block NL = R/64. Word handshake occurs when in_valid&&in_ready; block handshake when blk_valid&&blk_ready.
- State FILL:
  - in_ready=1, blk_valid=0.
  - Each accepted word writes lane[cnt]; bytes >= in_bytes are zeroed before the write; cnt increments.
  - Accepted word, !in_last, cnt==NL-1: go to EMIT, blk_last=0.
  - Accepted in_last word whose end byte position p = 8*cnt+in_bytes is < R/8:
    - byte p |= SUFFIX; byte R/8-1 |= 8'h80 (same byte gives 8'h86 when p == R/8-1);
    - go to EMIT, blk_last=1.
  - Accepted in_last word with p == R/8 (block exactly full): go to EMIT, blk_last=0, pad_pending=1.
- State EMIT:
  - in_ready=0, blk_valid=1.
  - blk_data and blk_last are held stable until handshake; no combinational path from blk_ready to blk_data.
  - On handshake with pad_pending=1: buffer = SUFFIX at byte 0 and 8'h80 at byte R/8-1, all other bytes 0; pad_pending=0; blk_last=1; stay in EMIT (state PAD is folded in via pad_pending).
  - On handshake otherwise: clear buffer, cnt=0, blk_last=0, return to FILL.
  - Output on the cycle after handshake is blk_valid=0 (FILL) or the pad block.
- Latency: blk_valid rises the cycle after the word that completes a block is accepted.
- Throughput: NL+1 cycles per block with continuous blk_ready.
- Empty message: in_last with in_bytes=0 at cnt=0 gives p=0, producing one block with byte0=SUFFIX and byte R/8-1=8'h80.
- in_bytes>8 with in_last is clamped to 8.
- Reset mid-message discards the partial buffer and any pad_pending; the next word starts a new message at lane 0.
- Inputs are ignored while in_ready=0.

Decomposition:
- Package sha3_pkg holds:
  - state enum {FILL, EMIT};
  - function rate_bits(D,B);
  - constants SHA3_SUFFIX=8'h06, SHAKE_SUFFIX=8'h1F, PAD_LAST=8'h80.
- Sub-module sha3_lane_mask: combinational; takes a 64-bit word and in_bytes, outputs the masked word plus a per-byte "first pad" one-hot used for SUFFIX insertion.
- The block-level top, FSM and counter stay in sha3_padder.

Test Plan:
1. Empty message (in_last=1, in_bytes=0, R=1088) -> one block, byte0=8'h06, byte135=8'h80, rest 0, blk_last=1.
2. "abc" (in_data=64'h636261, in_bytes=3, in_last) -> byte0..3 = 61 62 63 06, byte135=80, blk_last=1.
3. 135-byte message (16 full words + in_bytes=7 last) -> single block, byte135=8'h86, blk_last=1.
4. 136-byte message (17 full words, last word in_bytes=8) -> block1 = data, blk_last=0; then block2 = 06 at byte0, 80 at byte135, blk_last=1.
5. Backpressure: hold blk_ready=0 for 10 cycles during EMIT -> blk_data/blk_last stable, in_ready=0, no words consumed.
6. reset=0 after 5 words accepted -> next cycle in_ready=1, blk_valid=0; a new "abc" message produces the exact block from scenario 2.
